stopwatch_ctrl: RTL and testbench

//  Upstream control stage of the stopwatch: conditions the two raw active-low push buttons and runs the

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/btn_debounce.sv | 52 +++++
 rtl/stopwatch_ctrl.sv | 108 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and button indices.
// Used by the control stage and by the downstream count/display stages.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAP  = 2'd2,
        ST_STOP = 2'd3
    } sw_state_t;

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_LAP   = 1;
    localparam int unsigned NUM_BTN   = 2;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-FF synchronizer, stability counter and
// press-pulse generator for an active-low raw button.
//   CLK1, RST_N : clock, async active-low reset
//   btn         : raw active-low button (asynchronous)
//   stable      : debounced level (1 = released)
//   press       : one-cycle pulse one cycle after stable falls
module btn_debounce #(
    parameter int unsigned P_DEBOUNCE_CYCLES = 2**16
) (
    input  logic CLK1,
    input  logic RST_N,
    input  logic btn,
    output logic stable,
    output logic press
);

    localparam int unsigned CNT_W = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Synchronizer, stability counter and falling-edge pulse
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync2 != stable) begin
                // Terminal count is checked before incrementing, so cnt never wraps
                if (cnt == CNT_W'(P_DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: debounces the two buttons and runs the
// start/stop/lap/clear state machine, including long-press clear.
//   CLK1, RST_N : clock, async active-low reset
//   BTN[1:0]    : raw active-low buttons, [0]=start/stop, [1]=lap/clear
//   o_run       : time counter enable
//   o_lap_hold  : display frozen while counter runs
//   o_clear     : one-cycle pulse, zero the time counter
//   o_state     : current sw_state_t
//   o_press     : one-cycle debounced press pulses
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned P_DEBOUNCE_CYCLES   = 2**16,
    parameter int unsigned P_LONG_PRESS_CYCLES = 50_000_000
) (
    input  logic       CLK1,
    input  logic       RST_N,
    input  logic [1:0] BTN,
    output logic       o_run,
    output logic       o_lap_hold,
    output logic       o_clear,
    output logic [1:0] o_state,
    output logic [1:0] o_press
);

    localparam int unsigned LCNT_W = $clog2(P_LONG_PRESS_CYCLES + 1);

    logic [NUM_BTN-1:0] btn_stable;
    logic [LCNT_W-1:0]  lcnt;
    logic               long_hit_c;
    logic               unused_stable_start;
    sw_state_t          state;
    sw_state_t          state_d;
    logic               clear_d;

    // One conditioner per button
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK1  (CLK1),
            .RST_N (RST_N),
            .btn   (BTN[i]),
            .stable(btn_stable[i]),
            .press (o_press[i])
        );
    end

    assign unused_stable_start = btn_stable[BTN_START];

    // Long-press counter: stops one past the trigger value so it fires once per press
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            lcnt <= '0;
        end else if (btn_stable[BTN_LAP]) begin
            lcnt <= '0;
        end else if (lcnt != LCNT_W'(P_LONG_PRESS_CYCLES)) begin
            lcnt <= lcnt + LCNT_W'(1);
        end
    end

    assign long_hit_c = ~btn_stable[BTN_LAP] &&
                        (lcnt == LCNT_W'(P_LONG_PRESS_CYCLES - 1));

    // State and registered outputs
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            o_clear    <= 1'b0;
            o_run      <= 1'b0;
            o_lap_hold <= 1'b0;
        end else begin
            state      <= state_d;
            o_clear    <= clear_d;
            o_run      <= (state_d == ST_RUN) || (state_d == ST_LAP);
            o_lap_hold <= (state_d == ST_LAP);
        end
    end

    assign o_state = state;

    // Next state: long press beats lap/clear press beats start/stop press
    always_comb begin
        state_d = state;
        clear_d = 1'b0;
        if (long_hit_c) begin
            state_d = ST_IDLE;
            clear_d = 1'b1;
        end else if (o_press[BTN_LAP]) begin
            case (state)
                ST_IDLE: begin state_d = ST_IDLE; clear_d = 1'b1; end
                ST_RUN:  state_d = ST_LAP;
                ST_LAP:  state_d = ST_RUN;
                ST_STOP: begin state_d = ST_IDLE; clear_d = 1'b1; end
                default: state_d = ST_IDLE;
            endcase
        end else if (o_press[BTN_START]) begin
            case (state)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                ST_LAP:  state_d = ST_STOP;
                ST_STOP: state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a window-based reference model predicts
// press/clear/state events, a monitor matches them against DUT outputs.
module tb_stopwatch_ctrl;

    localparam int P_DB = 16;
    localparam int P_LP = 64;
    localparam int NX0[4] = '{1, 3, 3, 1};
    localparam int NX1[4] = '{0, 2, 1, 0};

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic       clr;
        logic [1:0] st;
    } ev_t;

    logic       CLK1;
    logic       RST_N;
    logic [1:0] BTN;
    logic       o_run;
    logic       o_lap_hold;
    logic       o_clear;
    logic [1:0] o_state;
    logic [1:0] o_press;

    int  cyc;
    int  n_checks;
    int  n_fail;
    ev_t exp_q[$];

    int press0_seen, press1_seen, clear_seen;
    int last_press0_cyc, last_clear_cyc;

    // Reference model state
    bit h0[$];
    bit h1[$];
    bit m_stable[2];
    int m_act[2];
    int m_flip[2];
    int m_tlow1;
    int m_state;

    stopwatch_ctrl #(
        .P_DEBOUNCE_CYCLES  (P_DB),
        .P_LONG_PRESS_CYCLES(P_LP)
    ) dut (
        .CLK1      (CLK1),
        .RST_N     (RST_N),
        .BTN       (BTN),
        .o_run     (o_run),
        .o_lap_hold(o_lap_hold),
        .o_clear   (o_clear),
        .o_state   (o_state),
        .o_press   (o_press)
    );

    initial CLK1 = 1'b0;
    always #10 CLK1 = ~CLK1;

    always @(posedge CLK1) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // A new debounced level is accepted once the raw samples taken
    // P_DB+1 .. 2 edges ago all disagree with the current level.
    function automatic bit window_flip(input bit h[$], input bit st);
        for (int j = 2; j <= P_DB + 1; j++)
            if (h[h.size() - 1 - j] == st) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        h0.delete();
        h1.delete();
        for (int j = 0; j < P_DB + 2; j++) begin
            h0.push_back(1'b1);
            h1.push_back(1'b1);
        end
        m_stable[0] = 1'b1;
        m_stable[1] = 1'b1;
        m_act[0] = -100;
        m_act[1] = -100;
        m_flip[0] = -100;
        m_flip[1] = -100;
        m_tlow1 = -100000;
        m_state = 0;
    endfunction

    function automatic void model_step();
        int   e;
        int   nst;
        bit   clr;
        bit   p0, p1, lng, f;
        logic [1:0] pv;
        ev_t  ev;
        e   = cyc + 1;
        lng = !m_stable[1] && (e == m_tlow1 + P_LP);
        p1  = (e == m_act[1]);
        p0  = (e == m_act[0]);
        nst = m_state;
        clr = 1'b0;
        if (lng) begin
            nst = 0;
            clr = 1'b1;
        end else if (p1) begin
            nst = NX1[m_state];
            clr = (nst == 0);
        end else if (p0) begin
            nst = NX0[m_state];
        end
        pv[0] = (e == m_flip[0] + 1);
        pv[1] = (e == m_flip[1] + 1);

        h0.push_back(BTN[0]);
        h1.push_back(BTN[1]);
        for (int b = 0; b < 2; b++) begin
            f = (b == 0) ? window_flip(h0, m_stable[0]) : window_flip(h1, m_stable[1]);
            if (f) begin
                m_stable[b] = !m_stable[b];
                if (!m_stable[b]) begin
                    m_flip[b] = e;
                    m_act[b]  = e + 2;
                    if (b == 1) m_tlow1 = e;
                end
            end
        end
        void'(h0.pop_front());
        void'(h1.pop_front());

        if (pv != 2'b00 || clr || nst != m_state) begin
            ev.cyc   = e;
            ev.press = pv;
            ev.clr   = clr;
            ev.st    = 2'(nst);
            exp_q.push_back(ev);
        end
        m_state = nst;
    endfunction

    // Model process
    initial begin
        model_reset();
        forever begin
            @(posedge CLK1 or negedge RST_N);
            if (!RST_N) model_reset();
            else        model_step();
        end
    end

    // Monitor: pop and compare on every observed event
    initial begin
        logic [1:0] prev_st;
        ev_t        ev;
        bit         dut_ev;
        prev_st = 2'd0;
        forever begin
            @(negedge CLK1);
            if (RST_N) begin
                dut_ev = (o_press != 2'b00) || o_clear || (o_state != prev_st);
                if (o_press[0]) begin press0_seen++; last_press0_cyc = cyc; end
                if (o_press[1]) press1_seen++;
                if (o_clear)    begin clear_seen++; last_clear_cyc = cyc; end
                if (dut_ev) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_event: press=%b clear=%b state=%0d at cycle %0d, expected no event",
                                 o_press, o_clear, o_state, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        check("ev_cycle", cyc, ev.cyc);
                        check("ev_press", int'(o_press), int'(ev.press));
                        check("ev_clear", int'(o_clear), int'(ev.clr));
                        check("ev_state", int'(o_state), int'(ev.st));
                        check("ev_run", int'(o_run), int'(ev.st == 2'd1 || ev.st == 2'd2));
                        check("ev_hold", int'(o_lap_hold), int'(ev.st == 2'd2));
                    end
                end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    ev = exp_q.pop_front();
                    check("missing_event_cycle", cyc, ev.cyc);
                end
            end
            prev_st = o_state;
        end
    end

    task automatic drive(input logic [1:0] b, input int n);
        BTN = b;
        repeat (n) @(negedge CLK1);
    endtask

    task automatic press_btn(input int b);
        drive((b == 0) ? 2'b10 : 2'b01, 40);
        drive(2'b11, 40);
        #2;
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        BTN   = 2'b11;
        repeat (n) @(negedge CLK1);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK1);
    endtask

    initial begin
        int k;
        int p0b, p1b, cb;
        int seq_b[5]  = '{0, 1, 1, 0, 1};
        int seq_st[5] = '{1, 2, 1, 3, 0};

        RST_N = 1'b0;
        BTN   = 2'b11;
        repeat (5) @(negedge CLK1);
        #1;
        check("rst_run", int'(o_run), 0);
        check("rst_hold", int'(o_lap_hold), 0);
        check("rst_clear", int'(o_clear), 0);
        check("rst_press", int'(o_press), 0);
        check("rst_state", int'(o_state), 0);
        @(negedge CLK1);
        RST_N = 1'b1;
        drive(2'b11, 5);

        // Glitch shorter than the debounce window
        p0b = press0_seen;
        drive(2'b10, 10);
        drive(2'b11, 40);
        #2;
        check("glitch_state", int'(o_state), 0);
        check("glitch_press", press0_seen - p0b, 0);

        // Bouncing start button, then held low
        p0b = press0_seen;
        for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 2'b10 : 2'b11, 5);
        BTN = 2'b10;
        k = cyc + 1;
        drive(2'b10, 40);
        drive(2'b11, 40);
        #2;
        check("bounce_press_count", press0_seen - p0b, 1);
        check("bounce_latency", last_press0_cyc - k, P_DB + 2);
        check("bounce_state", int'(o_state), 1);
        check("bounce_run", int'(o_run), 1);

        // Press sequence from idle
        do_reset(3);
        cb = clear_seen;
        for (int i = 0; i < 5; i++) begin
            press_btn(seq_b[i]);
            check("seq_state", int'(o_state), seq_st[i]);
            check("seq_hold", int'(o_lap_hold), int'(seq_st[i] == 2));
        end
        check("seq_clear_count", clear_seen - cb, 1);

        // Long press on lap/clear while running
        press_btn(0);
        check("long_pre_state", int'(o_state), 1);
        cb  = clear_seen;
        p1b = press1_seen;
        BTN = 2'b01;
        k = cyc + 1;
        drive(2'b01, 30);
        #2;
        check("long_lap_state", int'(o_state), 2);
        drive(2'b01, 170);
        #2;
        check("long_state", int'(o_state), 0);
        check("long_clear_count", clear_seen - cb, 1);
        check("long_clear_latency", last_clear_cyc - k, P_DB + 1 + P_LP);
        drive(2'b11, 40);
        #2;
        check("long_release_state", int'(o_state), 0);
        check("long_release_clear", clear_seen - cb, 1);
        check("long_press1_count", press1_seen - p1b, 1);

        // Both buttons together in stop
        press_btn(0);
        press_btn(0);
        check("stop_state", int'(o_state), 3);
        cb = clear_seen;
        drive(2'b00, 40);
        drive(2'b11, 40);
        #2;
        check("both_state", int'(o_state), 0);
        check("both_clear", clear_seen - cb, 1);

        // Reset in the middle of a debounce while running
        press_btn(0);
        check("mid_pre_state", int'(o_state), 1);
        p0b = press0_seen;
        drive(2'b10, 8);
        RST_N = 1'b0;
        #1;
        check("mid_rst_run", int'(o_run), 0);
        check("mid_rst_state", int'(o_state), 0);
        check("mid_rst_press", int'(o_press), 0);
        BTN = 2'b11;
        repeat (3) @(negedge CLK1);
        RST_N = 1'b1;
        drive(2'b11, 40);
        #2;
        check("mid_no_press", press0_seen - p0b, 0);
        check("mid_state", int'(o_state), 0);

        // Randomized button activity against the model
        for (int i = 0; i < 60; i++) begin
            int dur;
            dur = ($urandom_range(0, 5) == 0) ? int'($urandom_range(70, 120)) : int'($urandom_range(1, 40));
            drive(2'($urandom_range(0, 3)), dur);
        end
        drive(2'b11, 60);

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge CLK1);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
